// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous fetch FIFO. The head comes straight from storage, so it holds
// steady while decode stalls. Flush beats push and pop.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         do_push, do_pop;

  // The extra pointer bit tells full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  // Pointer and storage update; storage is cleared on reset so the head reads zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC register, combinational imem address,
// and a small FIFO feeding decode. Redirects flush the FIFO and reload PC.
// Optional macro FETCH_MISALIGN_CHECK_EN: a misaligned redirect sets a
// sticky flag that stops all fetching until reset; without it the redirect
// target is simply word-aligned.
import fetch_pkg::*;

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        if_ready,
  output logic        fetch_misaligned
);
  logic [XLEN-1:0] pc;
  logic            misaligned;
  logic            redirect_bad;
  logic            push, pop, full, empty;
  fetch_entry_t    wr_entry, head_entry;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign redirect_bad = redirect_valid & (redirect_pc[1:0] != 2'b00);

  // Sticky misalignment flag; only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst_n)            misaligned <= 1'b0;
    else if (redirect_bad) misaligned <= 1'b1;
  end
`else
  assign redirect_bad = 1'b0;
  assign misaligned   = 1'b0;
`endif

  assign fetch_misaligned = misaligned;
  assign imem_pc          = pc;

  // Redirect outranks both sides of the FIFO; a full FIFO still accepts a
  // push when the head leaves in the same cycle.
  assign pop  = ~empty & if_ready & ~redirect_valid;
  assign push = ~halt & ~redirect_valid & ~misaligned & (~full | pop);

  assign wr_entry.pc    = pc;
  assign wr_entry.instr = imem_instr;

  // Program counter: reset, redirect target (word aligned), or sequential step.
  always_ff @(posedge clk) begin
    if (!rst_n)                              pc <= RESET_PC;
    else if (redirect_valid & ~redirect_bad) pc <= redirect_pc & ~32'h3;
    else if (push)                           pc <= pc + PC_STEP;
  end

  fetch_fifo #(.DEPTH(DEPTH), .W(ENTRY_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (wr_entry),
    .full  (full),
    .empty (empty),
    .head  (head_entry)
  );

  assign if_valid = ~empty;
  assign if_instr = head_entry.instr;
  assign if_pc    = head_entry.pc;
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit with a queue-based reference model and a
// negedge monitor comparing the DUT head against the model queue front.
module tb_fetch_unit;
  localparam int DEPTH = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_pc, imem_instr, redirect_pc, if_instr, if_pc;
  logic        redirect_valid, halt, if_valid, if_ready, fetch_misaligned;

  int tot = 0;
  int bad = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  assign imem_instr = mem_word(imem_pc);

  fetch_unit #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem_pc          (imem_pc),
    .imem_instr       (imem_instr),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .halt             (halt),
    .if_valid         (if_valid),
    .if_instr         (if_instr),
    .if_pc            (if_pc),
    .if_ready         (if_ready),
    .fetch_misaligned (fetch_misaligned)
  );

  // Reference model: expected FIFO contents as a queue of {pc, instr}.
  logic [63:0] exp_q[$];
  logic [31:0] m_pc = RST_PC;
  logic        m_mis = 1'b0;
  logic        started = 1'b0;
  logic        last_rst = 1'b0;

  always @(posedge clk) begin
    bit do_pop, do_push;
    do_pop  = (exp_q.size() > 0) && if_ready && !redirect_valid;
    do_push = !halt && !redirect_valid && !m_mis && (exp_q.size() < DEPTH || do_pop);
    last_rst = !rst_n;
    if (!rst_n) begin
      exp_q.delete();
      m_pc  = RST_PC;
      m_mis = 1'b0;
    end else if (redirect_valid) begin
      exp_q.delete();
`ifdef FETCH_MISALIGN_CHECK_EN
      if (redirect_pc % 4 != 0) m_mis = 1'b1;
      else m_pc = redirect_pc;
`else
      m_pc = redirect_pc - (redirect_pc % 4);
`endif
    end else begin
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) begin
        exp_q.push_back({m_pc, mem_word(m_pc)});
        m_pc = m_pc + 32'd4;
      end
    end
    started = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tot++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: compare DUT outputs against the model away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      check("imem_pc", imem_pc, m_pc);
      check("if_valid", {31'b0, if_valid}, {31'b0, exp_q.size() > 0});
      check("misaligned", {31'b0, fetch_misaligned}, {31'b0, m_mis});
      if (if_valid && exp_q.size() > 0) begin
        check("if_pc", if_pc, exp_q[0][63:32]);
        check("if_instr", if_instr, exp_q[0][31:0]);
      end
      if (last_rst) begin
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_if_instr", if_instr, 32'h0);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic redirect(input logic [31:0] t);
    redirect_valid = 1'b1; redirect_pc = t;
    cyc(1);
    redirect_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cyc(2); rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0; if_ready = 1'b1;
    cyc(3);
    rst_n = 1'b1;
    cyc(6);                          // streaming, one per cycle
    if_ready = 1'b0; cyc(5);         // fill and stall
    if_ready = 1'b1; cyc(4);
    if_ready = 1'b0; cyc(3);
    redirect(32'h40);                // flush while full
    if_ready = 1'b1; cyc(4);
    halt = 1'b1; cyc(3); halt = 1'b0; cyc(3);
    redirect(32'hFFFF_FFF8); cyc(5); // PC wrap
    redirect(32'h42); cyc(5);        // misaligned target
    do_reset(); cyc(3);
    for (int i = 0; i < 3000; i++) begin
      if_ready = ($urandom_range(0, 9) < 6);
      halt     = ($urandom_range(0, 9) < 2);
      rst_n    = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 19) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = ($urandom_range(0, 7) == 0) ? $urandom() : ($urandom() & ~32'h3);
      end else begin
        redirect_valid = 1'b0;
      end
      cyc(1);
    end
    redirect_valid = 1'b0; halt = 1'b0; if_ready = 1'b1;
    do_reset(); cyc(4);
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end
endmodule
